// File: rtl/spi_peripheral_multimode.sv
// SPI peripheral, all four CPOL/CPHA modes, oversampled in the i_clk domain.
// One-word TX holding register, continuous multi-word frames, underrun/abort flags.
module spi_peripheral_multimode #(
    parameter int WORD_WIDTH  = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_spi_clk,
    input  logic                  i_spi_copi,
    input  logic                  i_spi_cs_n,
    output logic                  o_spi_cipo,
    output logic                  o_spi_cipo_oe,
    input  logic                  i_tx_dv,
    input  logic [WORD_WIDTH-1:0] i_tx_word,
    output logic                  o_tx_ready,
    output logic                  o_rx_dv,
    output logic [WORD_WIDTH-1:0] o_rx_word,
    output logic                  o_tx_underrun,
    output logic                  o_frame_err,
    output logic                  o_busy
);
    localparam int CW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] copi_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic                   sclk_d;
    logic                   cs_d;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk_q <= {SYNC_STAGES{CPOL}};
            copi_q <= '0;
            cs_q   <= '1;
            sclk_d <= CPOL;
            cs_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], i_spi_clk};
            copi_q <= {copi_q[SYNC_STAGES-2:0], i_spi_copi};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], i_spi_cs_n};
            sclk_d <= sclk_q[SYNC_STAGES-1];
            cs_d   <= cs_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic copi_s;
    logic cs_s;
    logic active;
    logic leading;
    logic trailing;
    logic sample_edge;
    logic shift_edge;
    logic frame_start;
    logic frame_end;

    assign sclk_s      = sclk_q[SYNC_STAGES-1];
    assign copi_s      = copi_q[SYNC_STAGES-1];
    assign cs_s        = cs_q[SYNC_STAGES-1];
    assign active      = ~cs_s;
    assign leading     = (sclk_d == CPOL) && (sclk_s != CPOL);
    assign trailing    = (sclk_d != CPOL) && (sclk_s == CPOL);
    assign sample_edge = active && (CPHA ? trailing : leading);
    assign shift_edge  = active && (CPHA ? leading : trailing);
    assign frame_start = cs_d && !cs_s;
    assign frame_end   = !cs_d && cs_s;

    logic [CW-1:0]         cnt;
    logic [WORD_WIDTH-1:0] tx_sr;
    logic [WORD_WIDTH-1:0] rx_sr;
    logic [WORD_WIDTH-1:0] hold;
    logic                  tx_ready;

    logic                  load;
    logic                  tx_accept;
    logic                  underrun;
    logic                  last_bit;
    logic [WORD_WIDTH-1:0] load_word;
    logic [WORD_WIDTH-1:0] rx_next;

    // With CPHA=0 the counter is back at 0 only after the last sample,
    // so the trailing edge that follows reloads for the next word.
    assign load = CPHA ? (shift_edge && cnt == '0)
                       : (frame_start || (shift_edge && cnt == '0));
    assign tx_accept = i_tx_dv && tx_ready;
    assign underrun  = load && tx_ready && !tx_accept;
    assign last_bit  = (cnt == LAST);

    always_comb begin
        load_word = '0;
        if (!tx_ready) begin
            load_word = hold;
        end else if (tx_accept) begin
            load_word = i_tx_word;
        end
        if (MSB_FIRST) begin
            rx_next = {rx_sr[WORD_WIDTH-2:0], copi_s};
        end else begin
            rx_next = {copi_s, rx_sr[WORD_WIDTH-1:1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold     <= '0;
            tx_ready <= 1'b1;
        end else if (load && !tx_ready) begin
            tx_ready <= 1'b1;
        end else if (tx_accept && !load) begin
            hold     <= i_tx_word;
            tx_ready <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_sr <= '0;
        end else if (load) begin
            tx_sr <= load_word;
        end else if (shift_edge) begin
            if (MSB_FIRST) begin
                tx_sr <= {tx_sr[WORD_WIDTH-2:0], 1'b0};
            end else begin
                tx_sr <= {1'b0, tx_sr[WORD_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt           <= '0;
            rx_sr         <= '0;
            o_rx_word     <= '0;
            o_rx_dv       <= 1'b0;
            o_frame_err   <= 1'b0;
            o_tx_underrun <= 1'b0;
        end else begin
            o_rx_dv       <= 1'b0;
            o_frame_err   <= frame_end && (cnt != '0);
            o_tx_underrun <= underrun;
            if (frame_end || frame_start) begin
                cnt   <= '0;
                rx_sr <= '0;
            end else if (sample_edge) begin
                rx_sr <= rx_next;
                if (last_bit) begin
                    cnt       <= '0;
                    o_rx_word <= rx_next;
                    o_rx_dv   <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign o_tx_ready    = tx_ready;
    assign o_busy        = active;
    assign o_spi_cipo_oe = active;
    assign o_spi_cipo    = active && (MSB_FIRST ? tx_sr[WORD_WIDTH-1] : tx_sr[0]);

endmodule

// File: tb/tb_spi_peripheral_multimode.sv
// Bench for spi_peripheral_multimode: five instances (modes 0-3 W=8, mode 0 W=16 LSB-first)
// driven by one bit-banged controller, RX words checked through a scoreboard.
module tb_spi_peripheral_multimode;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_clk;
    logic        spi_copi;
    logic [4:0]  cs_n;
    logic [4:0]  tx_dv;
    logic [15:0] tx_word;
    logic [4:0]  cipo;
    logic [4:0]  oe;
    logic [4:0]  tx_ready;
    logic [4:0]  rx_dv;
    logic [4:0]  unr;
    logic [4:0]  ferr;
    logic [4:0]  busy;
    logic [15:0] rx_word [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int W   = (g == 4) ? 16 : 8;
        localparam bit POL = (g == 2 || g == 3);
        localparam bit PHA = (g == 1 || g == 3);
        localparam bit MSB = (g != 4);
        logic [W-1:0] rxw;
        assign rx_word[g] = 16'(rxw);
        spi_peripheral_multimode #(
            .WORD_WIDTH(W), .CPOL(POL), .CPHA(PHA),
            .MSB_FIRST(MSB), .SYNC_STAGES(2)
        ) u_dut (
            .i_clk(clk),
            .i_reset_n(rst_n),
            .i_spi_clk(spi_clk),
            .i_spi_copi(spi_copi),
            .i_spi_cs_n(cs_n[g]),
            .o_spi_cipo(cipo[g]),
            .o_spi_cipo_oe(oe[g]),
            .i_tx_dv(tx_dv[g]),
            .i_tx_word(tx_word[W-1:0]),
            .o_tx_ready(tx_ready[g]),
            .o_rx_dv(rx_dv[g]),
            .o_rx_word(rxw),
            .o_tx_underrun(unr[g]),
            .o_frame_err(ferr[g]),
            .o_busy(busy[g])
        );
    end

    typedef struct {
        int          inst;
        logic [15:0] w;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   fe_cnt [5] = '{0, 0, 0, 0, 0};
    int   ur_cnt [5] = '{0, 0, 0, 0, 0};
    bit   cpol;
    bit   cpha;

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (ferr[i]) fe_cnt[i]++;
            if (unr[i]) ur_cnt[i]++;
            if (rx_dv[i]) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL rx_unexpected inst=%0d observed=%h expected=none", i, rx_word[i]);
                end
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    checks++;
                    assert (mon_e.inst == i && rx_word[i] === mon_e.w) else begin
                        failures++;
                        $error("FAIL rx_word inst=%0d observed=%h expected=%h (inst %0d)",
                               i, rx_word[i], mon_e.w, mon_e.inst);
                    end
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input int sel, input logic [15:0] w);
        int n = 0;
        while (!tx_ready[sel] && n < 100) begin
            wait_clk(1);
            n++;
        end
        chk($sformatf("tx_ready_wait_i%0d", sel), 32'(tx_ready[sel]), 32'd1);
        tx_word    = w;
        tx_dv[sel] = 1'b1;
        wait_clk(1);
        tx_dv[sel] = 1'b0;
    endtask

    task automatic cs_assert(input int sel);
        spi_clk = cpol;
        wait_clk(4);
        cs_n[sel] = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_release(input int sel);
        wait_clk(H);
        cs_n[sel] = 1'b1;
        wait_clk(6);
    endtask

    task automatic spi_xfer(input int sel, input int nbits, input int w,
                            input logic [31:0] mosi, input logic [31:0] miso,
                            input bit do_chk, input bit msb);
        for (int b = 0; b < nbits; b++) begin
            int idx;
            idx = msb ? (w - 1 - b) : b;
            if (!cpha) begin
                spi_copi = mosi[idx];
                wait_clk(H);
                if (do_chk)
                    chk($sformatf("cipo_i%0d_b%0d", sel, b), 32'(cipo[sel]), 32'(miso[idx]));
                spi_clk = ~cpol;
                wait_clk(H);
                spi_clk = cpol;
            end else begin
                spi_clk  = ~cpol;
                spi_copi = mosi[idx];
                wait_clk(H);
                if (do_chk)
                    chk($sformatf("cipo_i%0d_b%0d", sel, b), 32'(cipo[sel]), 32'(miso[idx]));
                spi_clk = cpol;
                wait_clk(H);
            end
        end
    endtask

    initial begin
        int fe0;
        int ur0;
        rst_n    = 1'b0;
        spi_clk  = 1'b0;
        spi_copi = 1'b0;
        cs_n     = '1;
        tx_dv    = '0;
        tx_word  = '0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(3);

        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst_ready_i%0d", i), 32'(tx_ready[i]), 32'd1);
            chk($sformatf("rst_busy_i%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst_oe_i%0d", i), 32'(oe[i]), 32'd0);
            chk($sformatf("rst_cipo_i%0d", i), 32'(cipo[i]), 32'd0);
            chk($sformatf("rst_rxw_i%0d", i), 32'(rx_word[i]), 32'd0);
        end

        // Mode 0 basic exchange, plus a write attempt while the holding register is full
        tx_write(0, 16'hA5);
        wait_clk(2);
        chk("t1_ready_low", 32'(tx_ready[0]), 32'd0);
        tx_word  = 16'hFF;
        tx_dv[0] = 1'b1;
        wait_clk(1);
        tx_dv[0] = 1'b0;
        sb.push_back('{0, 16'h3C});
        cs_assert(0);
        chk("t1_ready_after_load", 32'(tx_ready[0]), 32'd1);
        chk("t1_busy", 32'(busy[0]), 32'd1);
        chk("t1_oe", 32'(oe[0]), 32'd1);
        spi_xfer(0, 8, 8, 32'h3C, 32'hA5, 1'b1, 1'b1);
        cs_release(0);
        chk("t1_busy_end", 32'(busy[0]), 32'd0);
        chk("t1_ferr", 32'(fe_cnt[0]), 32'd0);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        for (int m = 0; m < 4; m++) begin
            cpol = m[1];
            cpha = m[0];
            tx_write(m, 16'h7E);
            sb.push_back('{m, 16'h81});
            cs_assert(m);
            spi_xfer(m, 8, 8, 32'h81, 32'h7E, 1'b1, 1'b1);
            cs_release(m);
            chk($sformatf("mode%0d_ferr", m), 32'(fe_cnt[m]), 32'd0);
            chk($sformatf("mode%0d_sb_empty", m), 32'(sb.size()), 32'd0);
        end

        // Three back-to-back 16-bit LSB-first words in one frame
        cpol = 1'b0;
        cpha = 1'b0;
        tx_write(4, 16'hCAFE);
        sb.push_back('{4, 16'h1234});
        sb.push_back('{4, 16'hBEEF});
        sb.push_back('{4, 16'h0001});
        cs_assert(4);
        tx_write(4, 16'h5A5A);
        spi_xfer(4, 16, 16, 32'h1234, 32'hCAFE, 1'b1, 1'b0);
        tx_write(4, 16'h8001);
        spi_xfer(4, 16, 16, 32'hBEEF, 32'h5A5A, 1'b1, 1'b0);
        spi_xfer(4, 16, 16, 32'h0001, 32'h8001, 1'b1, 1'b0);
        cs_release(4);
        chk("multi_ferr", 32'(fe_cnt[4]), 32'd0);
        chk("multi_sb_empty", 32'(sb.size()), 32'd0);

        // Underrun on the second word, mode 1
        cpol = 1'b0;
        cpha = 1'b1;
        ur0  = ur_cnt[1];
        tx_write(1, 16'hC3);
        sb.push_back('{1, 16'h5A});
        sb.push_back('{1, 16'hA5});
        cs_assert(1);
        spi_xfer(1, 8, 8, 32'h5A, 32'hC3, 1'b1, 1'b1);
        spi_xfer(1, 8, 8, 32'hA5, 32'h00, 1'b1, 1'b1);
        cs_release(1);
        chk("underrun_count", 32'(ur_cnt[1] - ur0), 32'd1);
        chk("underrun_ferr", 32'(fe_cnt[1]), 32'd0);
        chk("underrun_sb_empty", 32'(sb.size()), 32'd0);

        // Abort after 5 bits, then a clean frame
        cpol = 1'b0;
        cpha = 1'b0;
        fe0  = fe_cnt[0];
        cs_assert(0);
        spi_xfer(0, 5, 8, 32'hFF, 32'h00, 1'b0, 1'b1);
        cs_release(0);
        wait_clk(2);
        chk("abort_ferr", 32'(fe_cnt[0] - fe0), 32'd1);
        chk("abort_no_rx", 32'(sb.size()), 32'd0);
        tx_write(0, 16'h0F);
        sb.push_back('{0, 16'h55});
        cs_assert(0);
        spi_xfer(0, 8, 8, 32'h55, 32'h0F, 1'b1, 1'b1);
        cs_release(0);
        chk("after_abort_ferr", 32'(fe_cnt[0] - fe0), 32'd1);
        chk("after_abort_sb", 32'(sb.size()), 32'd0);

        // Reset in the middle of a word
        tx_write(0, 16'h33);
        cs_assert(0);
        spi_xfer(0, 3, 8, 32'hAA, 32'h00, 1'b0, 1'b1);
        fe0   = fe_cnt[0];
        rst_n = 1'b0;
        wait_clk(2);
        cs_n     = '1;
        spi_clk  = 1'b0;
        spi_copi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        chk("rst2_ready", 32'(tx_ready[0]), 32'd1);
        chk("rst2_busy", 32'(busy[0]), 32'd0);
        chk("rst2_oe", 32'(oe[0]), 32'd0);
        chk("rst2_cipo", 32'(cipo[0]), 32'd0);
        chk("rst2_rxw", 32'(rx_word[0]), 32'd0);
        chk("rst2_ferr", 32'(fe_cnt[0] - fe0), 32'd0);
        tx_write(0, 16'h3C);
        sb.push_back('{0, 16'hC3});
        cs_assert(0);
        spi_xfer(0, 8, 8, 32'hC3, 32'h3C, 1'b1, 1'b1);
        cs_release(0);
        chk("rst2_next_ferr", 32'(fe_cnt[0] - fe0), 32'd0);

        wait_clk(10);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
